// File: rtl/if_id_queue.sv
// IF/ID queue: a DEPTH-entry circular buffer of (pc, inst) pairs between fetch and decode.
// When the queue is empty, the head is presented as a zero bubble.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_valid_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [INST_W-1:0] push_inst_i,
  output logic              push_ready_o,
  output logic              almost_full_o,
  input  logic              stall_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pcMem_q   [DEPTH];
  logic [INST_W-1:0] instMem_q [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic pushEn;
  logic popEn;

  // Status flags come only from registered count, so stall_i never reaches push_ready_o.
  assign push_ready_o  = (count_q != CNT_W'(DEPTH));
  assign almost_full_o = (count_q >= CNT_W'(DEPTH - 1));
  assign id_valid_o    = (count_q != '0);
  assign count_o       = count_q;

  assign id_pc_o   = id_valid_o ? pcMem_q[rdPtr_q]   : '0;
  assign id_inst_o = id_valid_o ? instMem_q[rdPtr_q] : '0;

  assign pushEn = push_valid_i && push_ready_o;
  assign popEn  = id_valid_o && !stall_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEn) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (pushEn && !popEn) begin
      count_d = count_q + CNT_W'(1);
    end else if (popEn && !pushEn) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Flush behaves exactly like reset on pointers and count; any push or pop in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn && !rst && !flush_i) begin
      pcMem_q[wrPtr_q]   <= push_pc_i;
      instMem_q[wrPtr_q] <= push_inst_i;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic,
// checked by a scoreboard queue fed from stimulus and drained by an output monitor.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        push_valid_i;
  logic [31:0] push_pc_i;
  logic [31:0] push_inst_i;
  logic        push_ready_o;
  logic        almost_full_o;
  logic        stall_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_pc_i    (push_pc_i),
    .push_inst_i  (push_inst_i),
    .push_ready_o (push_ready_o),
    .almost_full_o(almost_full_o),
    .stall_i      (stall_i),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: entries the queue should currently hold, oldest first.
  logic [63:0] expQ[$];
  int          modelCount   = 0;
  int          expCount     = 0;
  bit          clearPending = 1'b0;
  bit          checkEn      = 1'b0;
  int          total        = 0;
  int          bad          = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the coming edge.
  task automatic applyStimulus(input logic r, input logic f, input logic pv,
                               input logic [31:0] pc, input logic [31:0] inst,
                               input logic s);
    bit accept;
    bit pop;
    if (clearPending) begin
      expQ.delete();
      clearPending = 1'b0;
    end
    expCount     = modelCount;
    rst          = r;
    flush_i      = f;
    push_valid_i = pv;
    push_pc_i    = pc;
    push_inst_i  = inst;
    stall_i      = s;
    if (r || f) begin
      modelCount   = 0;
      clearPending = 1'b1;
    end else begin
      accept = pv && (modelCount < DEPTH);
      pop    = (modelCount > 0) && !s;
      if (accept) expQ.push_back({pc, inst});
      modelCount = modelCount + int'(accept) - int'(pop);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic s);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, s);
  endtask

  task automatic checkOutput();
    logic [63:0] head;
    cmp("count_o", 64'(count_o), 64'(expCount));
    cmp("id_valid_o", 64'(id_valid_o), 64'(expCount != 0));
    cmp("push_ready_o", 64'(push_ready_o), 64'(expCount != DEPTH));
    cmp("almost_full_o", 64'(almost_full_o), 64'(expCount >= DEPTH - 1));
    if (id_valid_o) begin
      if (expQ.size() == 0) begin
        cmp("head_present", 64'(id_pc_o), 64'hDEAD_0000_0000_0000);
      end else begin
        head = (!stall_i) ? expQ.pop_front() : expQ[0];
        cmp("id_pc_o", 64'(id_pc_o), 64'(head[63:32]));
        cmp("id_inst_o", 64'(id_inst_o), 64'(head[31:0]));
      end
    end else begin
      cmp("bubble_pc", 64'(id_pc_o), 64'h0);
      cmp("bubble_inst", 64'(id_inst_o), 64'h0);
    end
  endtask

  // Monitor: samples half a cycle after each edge, away from input changes.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) checkOutput();
    end
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0;
    push_pc_i = '0; push_inst_i = '0; stall_i = 1'b0;
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkEn = 1'b1;

    $display("[TB] single push, one-cycle latency");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000, 32'h0000_0013, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] fill under stall, overflow push ignored");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hBAD0_0010, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b0);

    $display("[TB] continuous streaming with pointer wrap");
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h400 + 32'(i * 4), 32'hC000_0000 ^ 32'(i), 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] flush with simultaneous push");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'hBAD0_0200, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] pop from full, retried push");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h500 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h510, 32'hE000_0010, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h510, 32'hE000_0010, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 32'hF000_0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h604, 32'hF000_0001, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 32'h0000_0300, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 9) < 7), $urandom(), $urandom(),
                    ($urandom_range(0, 9) < 4));
    end
    for (int i = 0; i < 6; i++) idle(1'b0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
